if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage sitting directly upstream of the byte-addressed 128-byte instruction memory. It owns the program counter, drives the memory's 7-bit byte address, and captures the returned 32-bit big-endian word into the IF/ID pipeline register. The stage supports stall, flush, branch/jump redirect, out-of-range fetch protection, and a delivered-instruction counter. The decode stage consumes its IF/ID outputs.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IMEM_BYTES, 128, instruction memory size in bytes; must equal the memory's size
- NOP_INSTR, 32'h0000_0000, word inserted into IF/ID on bubbles

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- im_addr  out  7  byte address to instruction memory; combinational, equals pc[6:0]
- im_instr  in  32  word returned by instruction memory for im_addr; combinational
- stall  in  1  hold PC and IF/ID contents
- flush  in  1  replace IF/ID contents with a bubble
- redirect  in  1  load redirect_pc into PC; implies flush
- redirect_pc  in  32  target byte address
- pc  out  32  current fetch PC (register)
- ifid_instr  out  32  registered instruction
- ifid_pc  out  32  PC of ifid_instr
- ifid_pc4  out  32  ifid_pc + 4
- ifid_valid  out  1  IF/ID holds a real instruction
- fetch_err  out  1  sticky: an illegal fetch address was reached
- fetch_count  out  32  number of instructions delivered with ifid_valid=1

## Operation
- Legal fetch: pc[1:0]==0 and pc <= IMEM_BYTES-4 (pc upper bits above [6:0] must be zero). Otherwise the fetch is illegal.
- Per-edge priority, highest first:
  - redirect=1: pc <= redirect_pc; IF/ID <= bubble. Overrides stall and flush.
  - stall=1 and flush=1: pc holds; IF/ID <= bubble.
  - stall=1: pc and IF/ID hold.
  - flush=1: pc advances as in the normal case; IF/ID <= bubble.
  - Normal, legal fetch: pc <= pc+4; ifid_instr <= im_instr; ifid_pc <= pc; ifid_pc4 <= pc+4; ifid_valid <= 1.
  - Normal, illegal fetch: pc holds; IF/ID <= bubble; fetch_err <= 1.
- Bubble: ifid_instr=NOP_INSTR, ifid_valid=0. ifid_pc and ifid_pc4 hold their previous values.
- fetch_err is sticky until rst. A redirect to a legal address resumes fetching, but fetch_err stays at 1.
- fetch_count increments by 1 on each edge where ifid_valid is written to 1. It wraps modulo 2^32.
- pc+4 is 32-bit arithmetic with wrap. It never reaches the memory, because an illegal pc holds.

## Timing
- Reset (async, immediate on rst=1): pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc4=0, ifid_valid=0, fetch_err=0, fetch_count=0.
- After rst deasserts, the first edge captures the word at RESET_PC. ifid_valid=1 one cycle after release.
- Fetch latency: im_addr follows pc in the same cycle. The instruction at PC=A appears on ifid_instr one edge after pc==A.
- Throughput: one instruction per cycle when there is no stall, flush, or redirect.
- Redirect penalty: the cycle after the redirect edge shows a bubble. The target instruction appears one edge later.
- rst asserted mid-operation wins over all inputs and resets all state. No partial update occurs.
- stall has no effect on fetch_err or fetch_count, except through the rules above.

## Test plan
- Reset and stream: memory at 0..15 holds 0x11111111, 0x22222222, 0x33333333, 0x44444444 (big-endian bytes). Release rst -> ifid_instr shows 0x11111111/0x22222222/0x33333333 on consecutive cycles; ifid_pc=0/4/8; ifid_pc4=4/8/12; fetch_count=3.
- Stall: stall=1 for 2 cycles while ifid_pc=4 -> pc=8 and ifid_instr=0x22222222 held for 2 cycles, then 0x33333333 arrives; fetch_count not incremented during the stall.
- Redirect: redirect=1 with redirect_pc=0x40 while stall=1 -> next cycle pc=0x40, ifid_valid=0, ifid_instr=NOP_INSTR; the following cycle ifid_pc=0x40 with the memory word at 0x40.
- Flush only at pc=0x8 -> IF/ID bubble, pc=0xC, fetch_count unchanged; the next cycle delivers the word at 0xC.
- Out of range: run to pc=0x7C, then advance -> 0x7C word is delivered; at pc=0x80, fetch_err=1, pc holds at 0x80, ifid_valid=0; redirect to 0x0 resumes fetching with fetch_err still 1. Also, redirect_pc=0x6 -> fetch_err=1 and pc holds at 0x6.
- Async reset mid-stream: assert rst between edges at pc=0x20 -> all outputs take their reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory and
// loads the returned word into the IF/ID pipeline register. Handles stall,
// flush, redirect, out-of-range fetch protection and a delivered-instruction count.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 128,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [6:0]  im_addr,
    input  logic [31:0] im_instr,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        fetch_err,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] LAST_WORD_ADDR = 32'(IMEM_BYTES - 4);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] ifpc4_q, ifpc4_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc_plus4;
    logic        fetch_legal;

    assign pc_plus4    = pc_q + 32'd4;
    assign fetch_legal = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_WORD_ADDR);

    // Next-state selection in priority order: redirect, stall+flush, stall,
    // then normal fetch where an illegal pc holds and flags the error.
    // A flush at an illegal pc behaves as the illegal normal case (pc holds,
    // error flagged) since the bubble it inserts is identical either way.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        ifpc4_d = ifpc4_q;
        valid_d = valid_q;
        err_d   = err_q;
        count_d = count_q;
        if (redirect) begin
            pc_d    = redirect_pc;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (stall && flush) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (stall) begin
            // hold everything
        end else if (!fetch_legal) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            err_d   = 1'b1;
        end else if (flush) begin
            pc_d    = pc_plus4;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else begin
            pc_d    = pc_plus4;
            instr_d = im_instr;
            ifpc_d  = pc_q;
            ifpc4_d = pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ifpc_q  <= '0;
            ifpc4_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            ifpc4_q <= ifpc4_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign im_addr     = pc_q[6:0];
    assign pc          = pc_q;
    assign ifid_instr  = instr_q;
    assign ifid_pc     = ifpc_q;
    assign ifid_pc4    = ifpc4_q;
    assign ifid_valid  = valid_q;
    assign fetch_err   = err_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed steps from the test plan followed by random
// stall/flush/redirect traffic, all compared against a behavioural model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  im_addr;
    logic [31:0] im_instr;
    logic        stall, flush, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc, ifid_instr, ifid_pc, ifid_pc4, fetch_count;
    logic        ifid_valid, fetch_err;

    logic [7:0] mem [128];

    int checks = 0;
    int failures = 0;

    // model state
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
    logic        m_valid, m_err;

    if_stage #(
        .RESET_PC(32'h0000_0000),
        .IMEM_BYTES(128),
        .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .rst(rst), .im_addr(im_addr), .im_instr(im_instr),
        .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
        .pc(pc), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
        .ifid_valid(ifid_valid), .fetch_err(fetch_err), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // big-endian read from the byte memory, address wrapping within 128 bytes
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [6:0] b;
        b = a[6:0];
        return {mem[b], mem[7'(b + 7'd1)], mem[7'(b + 7'd2)], mem[7'(b + 7'd3)]};
    endfunction

    assign im_instr = word_at({25'd0, im_addr});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = NOP; m_ipc = 32'h0; m_ipc4 = 32'h0;
        m_valid = 1'b0; m_err = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic check_all();
        chk("pc", pc, m_pc);
        chk("im_addr", {25'd0, im_addr}, {25'd0, m_pc[6:0]});
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_pc", ifid_pc, m_ipc);
        chk("ifid_pc4", ifid_pc4, m_ipc4);
        chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
        chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
        chk("fetch_count", fetch_count, m_cnt);
    endtask

    // one clock edge: apply inputs, advance the model from the rules, compare
    task automatic tick(input logic s, input logic f, input logic r, input logic [31:0] rp);
        bit legal;
        stall = s; flush = f; redirect = r; redirect_pc = rp;
        legal = (m_pc % 4 == 0) && (m_pc <= 32'd124);
        if (r) begin
            m_pc = rp; m_instr = NOP; m_valid = 1'b0;
        end else if (s && f) begin
            m_instr = NOP; m_valid = 1'b0;
        end else if (s) begin
        end else if (!legal) begin
            m_instr = NOP; m_valid = 1'b0; m_err = 1'b1;
        end else if (f) begin
            m_instr = NOP; m_valid = 1'b0; m_pc = m_pc + 4;
        end else begin
            m_instr = word_at(m_pc); m_ipc = m_pc; m_ipc4 = m_pc + 4;
            m_valid = 1'b1; m_cnt = m_cnt + 1; m_pc = m_pc + 4;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) begin
            w = {4{4'(i + 1), 4'(i + 1)}};
            mem[4*i]   = w[31:24];
            mem[4*i+1] = w[23:16];
            mem[4*i+2] = w[15:8];
            mem[4*i+3] = w[7:0];
        end
        stall = 0; flush = 0; redirect = 0; redirect_pc = 0;

        // reset and stream
        rst = 1'b1;
        model_reset();
        #12;
        check_all();
        release_rst();
        run(3);
        chk("stream_instr3", ifid_instr, 32'h3333_3333);
        chk("stream_pc3", ifid_pc, 32'h8);
        chk("stream_pc4_3", ifid_pc4, 32'hC);
        chk("stream_count3", fetch_count, 32'd3);

        // stall while ifid_pc=4
        rst = 1'b1; model_reset(); #1; release_rst();
        run(2);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("stall_pc", pc, 32'h8);
        chk("stall_instr", ifid_instr, 32'h2222_2222);
        chk("stall_count", fetch_count, 32'd2);
        tick(0, 0, 0, 0);
        chk("after_stall_instr", ifid_instr, 32'h3333_3333);

        // redirect overriding stall
        tick(1, 0, 1, 32'h40);
        chk("redir_pc", pc, 32'h40);
        chk("redir_valid", {31'd0, ifid_valid}, 32'd0);
        tick(0, 0, 0, 0);
        chk("redir_target_pc", ifid_pc, 32'h40);

        // flush only at pc=8
        tick(0, 0, 1, 32'h8);
        tick(0, 1, 0, 0);
        chk("flush_pc", pc, 32'hC);
        tick(0, 0, 0, 0);
        chk("flush_next_pc", ifid_pc, 32'hC);

        // out of range
        tick(0, 0, 1, 32'h70);
        run(4);
        chk("last_word_pc", ifid_pc, 32'h7C);
        run(1);
        chk("oor_err", {31'd0, fetch_err}, 32'd1);
        chk("oor_pc", pc, 32'h80);
        run(1);
        tick(0, 0, 1, 32'h0);
        run(2);
        chk("resume_valid", {31'd0, ifid_valid}, 32'd1);
        chk("resume_err", {31'd0, fetch_err}, 32'd1);
        rst = 1'b1; model_reset(); #1; release_rst();
        tick(0, 0, 1, 32'h6);
        run(2);
        chk("unaligned_pc", pc, 32'h6);

        // async reset mid-stream at pc=0x20
        tick(0, 0, 1, 32'h10);
        run(4);
        chk("pre_async_pc", pc, 32'h20);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        release_rst();

        // randomized traffic with occasional async resets
        for (int i = 0; i < 600; i++) begin
            logic s, f, r;
            logic [31:0] rp;
            s = ($urandom_range(0, 4) == 0);
            f = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 5))
                0:       rp = $urandom;
                1:       rp = 32'($urandom_range(0, 140));
                default: rp = 32'($urandom_range(0, 31)) * 4;
            endcase
            tick(s, f, r, rp);
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b1;
                #1 model_reset();
                check_all();
                release_rst();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
